// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the execute stage (requester 0) and the
// debug/tester port (requester 1). Round-robin grant, operands captured at
// accept, start/done handshake to the ALU with an optional timeout, and the
// result returned on the owning requester's response channel.
module alu_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPER_WIDTH     = 4,
  parameter int FLAGS_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*OPER_WIDTH-1:0]   req_oper,
  input  logic [2*DATA_WIDTH-1:0]   req_a,
  input  logic [2*DATA_WIDTH-1:0]   req_b,
  output logic [1:0]                resp_valid,
  input  logic [1:0]                resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_result,
  output logic [FLAGS_WIDTH-1:0]    resp_flags,
  output logic                      resp_err,
  output logic                      alu_start,
  output logic [OPER_WIDTH-1:0]     alu_oper,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  input  logic                      alu_done,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [FLAGS_WIDTH-1:0]    alu_flags,
  output logic [COUNT_WIDTH-1:0]    op_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Wait counter is wide enough to reach TIMEOUT_CYCLES-1; it is never
  // compared when the timeout is disabled.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]             state_reg;
  logic                   last_grant_reg;
  logic                   owner_reg;
  logic [OPER_WIDTH-1:0]  oper_reg;
  logic [DATA_WIDTH-1:0]  a_reg;
  logic [DATA_WIDTH-1:0]  b_reg;
  logic [DATA_WIDTH-1:0]  result_reg;
  logic [FLAGS_WIDTH-1:0] flags_reg;
  logic                   err_reg;
  logic [TW-1:0]          wait_cnt_reg;
  logic [COUNT_WIDTH-1:0] count_reg;

  logic grant_valid;
  logic grant_id;

  // Round-robin pick: favour the requester that did not win last time.
  // Depends only on state, enable, req_valid and last_grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_reg == S_IDLE && enable) begin
      if (req_valid[~last_grant_reg]) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_reg;
      end else if (req_valid[last_grant_reg]) begin
        grant_valid = 1'b1;
        grant_id    = last_grant_reg;
      end
    end
  end

  // Per-requester handshake outputs; at most one bit of each is ever set.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign req_ready[gi]  = grant_valid && (grant_id == 1'(gi));
    assign resp_valid[gi] = (state_reg == S_RESP) && (owner_reg == 1'(gi));
  end

  assign alu_start   = (state_reg == S_ISSUE);
  assign alu_oper    = oper_reg;
  assign alu_a       = a_reg;
  assign alu_b       = b_reg;
  assign resp_result = result_reg;
  assign resp_flags  = flags_reg;
  assign resp_err    = err_reg;
  assign op_count    = count_reg;

  // Sequencer: accept, issue, wait for done or timeout, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      oper_reg       <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      result_reg     <= '0;
      flags_reg      <= '0;
      err_reg        <= 1'b0;
      wait_cnt_reg   <= '0;
      count_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_valid) begin
            owner_reg      <= grant_id;
            last_grant_reg <= grant_id;
            oper_reg       <= grant_id ? req_oper[2*OPER_WIDTH-1:OPER_WIDTH] : req_oper[OPER_WIDTH-1:0];
            a_reg          <= grant_id ? req_a[2*DATA_WIDTH-1:DATA_WIDTH]    : req_a[DATA_WIDTH-1:0];
            b_reg          <= grant_id ? req_b[2*DATA_WIDTH-1:DATA_WIDTH]    : req_b[DATA_WIDTH-1:0];
            state_reg      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt_reg <= '0;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          // A done in the same cycle as the timeout still delivers the result.
          if (alu_done) begin
            result_reg <= alu_result;
            flags_reg  <= alu_flags;
            err_reg    <= 1'b0;
            state_reg  <= S_RESP;
          end else if (TIMEOUT_CYCLES > 0 && wait_cnt_reg == T_LAST) begin
            result_reg <= '0;
            flags_reg  <= '0;
            err_reg    <= 1'b1;
            state_reg  <= S_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready[owner_reg]) begin
            count_reg <= count_reg + 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction/timestamp model of the arbiter.
module tb_alu_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0]  req_oper;
  logic [63:0] req_a, req_b;
  logic [31:0] resp_result, alu_a, alu_b, alu_result;
  logic [3:0]  resp_flags, alu_oper, alu_flags;
  logic        resp_err, alu_start, alu_done;
  logic [15:0] op_count;

  alu_arbiter #(.DATA_WIDTH(32), .OPER_WIDTH(4), .FLAGS_WIDTH(4),
                .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_oper(req_oper),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_start(alu_start), .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model: one in-flight transaction described by timestamps.
  bit          m_busy, m_owner, m_lastg, m_clear, m_err;
  int          m_s, m_r, m_d;
  logic [3:0]  m_oper, m_flags;
  logic [31:0] m_a, m_b, m_res;
  logic [15:0] m_count;
  bit          rand_mode, force_done;
  int          next_delay;
  int          grant_log[$];
  int          resp_log[$];
  int          dtbl[10] = '{0, 1, 1, 2, 3, 5, 15, 16, 17, 1000};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
  endtask

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a ^ b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [3:0] flags_fn(input logic [31:0] r, input logic [3:0] op);
    return {r[31], (r == 32'd0), op[1:0]};
  endfunction

  // Returns {granted, id}: the requester that did not win last time is preferred.
  function automatic logic [1:0] pick(input logic [1:0] v, input bit lastg, input bit en);
    int other;
    other = 1 - int'(lastg);
    if (!en) return 2'b00;
    if (v[other]) return {1'b1, 1'(other)};
    if (v[int'(lastg)]) return {1'b1, lastg};
    return 2'b00;
  endfunction

  // Drive the bench ALU, let logic settle, compare DUT against the model.
  task automatic settle();
    logic [1:0] g;
    bit in_resp, noise_ok;
    if (m_busy && cyc == m_s + m_d) begin
      alu_done   = 1'b1;
      alu_result = alu_fn(m_oper, m_a, m_b);
      alu_flags  = flags_fn(alu_result, m_oper);
    end else begin
      noise_ok   = !m_busy || cyc == m_s || cyc >= m_r;
      alu_done   = force_done || (rand_mode && noise_ok && $urandom_range(0, 3) == 0);
      alu_result = $urandom;
      alu_flags  = 4'($urandom);
    end
    #1;
    g = pick(req_valid, m_lastg, enable);
    in_resp = m_busy && cyc >= m_r;
    check("req_ready", req_ready, (!m_busy && g[1]) ? (2'b01 << g[0]) : 2'b00);
    check("alu_start", alu_start, m_busy && cyc == m_s);
    check("resp_valid", resp_valid, in_resp ? (2'b01 << m_owner) : 2'b00);
    check("op_count", op_count, m_count);
    if (in_resp) begin
      check("resp_result", resp_result, m_res);
      check("resp_flags", resp_flags, m_flags);
      check("resp_err", resp_err, m_err);
    end
    if (m_busy && !in_resp) begin
      check("alu_oper", alu_oper, m_oper);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
    end
    if (m_clear) begin
      check("clr_oper", alu_oper, 0);
      check("clr_a", alu_a, 0);
      check("clr_b", alu_b, 0);
      check("clr_result", resp_result, 0);
      check("clr_flags", resp_flags, 0);
      check("clr_err", resp_err, 0);
    end
  endtask

  // Apply this cycle's clock edge to the model, then move to the next cycle.
  task automatic advance();
    logic [1:0] g;
    if (rst) begin
      m_busy = 0; m_lastg = 1; m_count = 0; m_clear = 1;
    end else if (!m_busy) begin
      g = pick(req_valid, m_lastg, enable);
      if (g[1]) begin
        m_busy  = 1;
        m_clear = 0;
        m_owner = g[0];
        m_lastg = g[0];
        grant_log.push_back(int'(g[0]));
        m_oper  = g[0] ? req_oper[7:4]  : req_oper[3:0];
        m_a     = g[0] ? req_a[63:32]   : req_a[31:0];
        m_b     = g[0] ? req_b[63:32]   : req_b[31:0];
        m_s     = cyc + 1;
        m_d     = rand_mode ? dtbl[$urandom_range(0, 9)] : next_delay;
        if (m_d >= 1 && m_d <= TO) begin
          m_res = alu_fn(m_oper, m_a, m_b); m_flags = flags_fn(m_res, m_oper);
          m_err = 0; m_r = m_s + m_d + 1;
        end else begin
          m_res = 0; m_flags = 0; m_err = 1; m_r = m_s + TO + 1;
        end
      end
    end else if (cyc >= m_r && resp_ready[m_owner]) begin
      m_busy  = 0;
      m_count = m_count + 16'd1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    resp_ready = 2'b11;
    req_valid  = 2'b00;
    for (int i = 0; i < 60 && m_busy; i++) begin
      settle();
      advance();
    end
  endtask

  initial begin
    int t_acc, waited;
    rst = 1; enable = 0; req_valid = 0; req_oper = 0; req_a = 0; req_b = 0;
    resp_ready = 0; alu_done = 0; alu_result = 0; alu_flags = 0;
    m_busy = 0; m_lastg = 1; m_count = 0; m_clear = 1; m_owner = 0;
    m_s = 0; m_r = 0; m_d = 0; rand_mode = 0; force_done = 0; next_delay = 1;
    @(negedge clk);

    // Reset state
    settle();
    check("rst_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_start", alu_start, 0);
    check("rst_count", op_count, 0);
    advance();
    rst = 0;

    // 1: requester 0 ADD 5+7, ALU done one cycle after start
    enable = 1; req_valid = 2'b01; req_oper = 8'h00; req_a = 64'd5; req_b = 64'd7; next_delay = 1;
    settle(); check("t1_ready", req_ready, 2'b01); advance();
    req_valid = 0;
    settle(); check("t1_start", alu_start, 1); advance();
    settle(); advance();
    resp_ready = 2'b01;
    settle(); check("t1_resp_valid", resp_valid, 2'b01); check("t1_result", resp_result, 12); advance();
    resp_ready = 0;
    settle(); check("t1_count", op_count, 1); advance();

    // 3: requester 1, ALU never answers -> timeout
    req_valid = 2'b10; req_oper = 8'h10; req_a = {32'd100, 32'd0}; req_b = {32'd1, 32'd0}; next_delay = 1000;
    settle(); check("t3_ready", req_ready, 2'b10); t_acc = cyc; advance();
    req_valid = 0;
    settle();
    waited = 0;
    while (resp_valid == 2'b00 && waited < 40) begin
      advance(); settle(); waited++;
    end
    check("t3_latency", 64'(cyc - t_acc), 18);
    check("t3_err", resp_err, 1);
    check("t3_result", resp_result, 0);
    check("t3_flags", resp_flags, 0);
    // 4: response held while resp_ready is low; non-owner ready ignored
    for (int i = 0; i < 5; i++) begin
      advance();
      req_valid = 2'b11;
      resp_ready = (i == 4) ? 2'b01 : 2'b00;
      settle();
      check("t4_valid", resp_valid, 2'b10);
      check("t4_no_ready", req_ready, 2'b00);
    end
    advance();
    resp_ready = 2'b10; enable = 0;
    settle(); check("t4_valid_last", resp_valid, 2'b10); advance();
    resp_ready = 0;

    // 6: enable low blocks grants; re-enabling grants requester 0
    for (int i = 0; i < 3; i++) begin
      settle(); check("t6_blocked", req_ready, 2'b00); advance();
    end
    enable = 1; next_delay = 2; req_oper = 8'h23; req_a = {32'd9, 32'hF0}; req_b = {32'd3, 32'h0F};
    settle(); check("t6_grant0", req_ready, 2'b01); advance();
    drain();
    check("t6_count", op_count, 3);

    // 5: reset during WAIT drops the op; late alu_done ignored
    enable = 1; req_valid = 2'b01; next_delay = 1000; resp_ready = 0;
    settle(); advance();
    req_valid = 0;
    settle(); advance();
    settle(); advance();
    rst = 1;
    settle(); advance();
    rst = 0; force_done = 1;
    settle();
    check("t5_resp_valid", resp_valid, 2'b00);
    check("t5_alu_oper", alu_oper, 0);
    check("t5_alu_a", alu_a, 0);
    check("t5_count", op_count, 0);
    advance();
    settle();
    check("t5_late_done", resp_valid, 2'b00);
    check("t5_no_start", alu_start, 0);
    advance();
    force_done = 0;

    // 2: both requesting for three ops -> grants 0,1,0
    grant_log.delete(); resp_log.delete();
    req_valid = 2'b11; resp_ready = 2'b11; next_delay = 1;
    for (int i = 0; i < 60 && !(grant_log.size() >= 3 && !m_busy); i++) begin
      if (grant_log.size() >= 3) req_valid = 2'b00;
      settle();
      check("t2_one_hot", req_ready == 2'b11, 0);
      if (resp_valid == 2'b01) resp_log.push_back(0);
      else if (resp_valid == 2'b10) resp_log.push_back(1);
      advance();
    end
    check("t2_n_resp", resp_log.size(), 3);
    if (resp_log.size() >= 3) begin
      check("t2_owner0", resp_log[0], 0);
      check("t2_owner1", resp_log[1], 1);
      check("t2_owner2", resp_log[2], 0);
    end

    // Randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      req_valid  = 2'($urandom);
      req_oper   = 8'($urandom);
      req_a      = {$urandom, $urandom};
      req_b      = {$urandom, $urandom};
      resp_ready = 2'($urandom);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
